// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is unused; the FSM treats it as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor. The master
// modport is the producer of operands and consumer of results; the slave
// modport is the subtractor itself.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow_out, ovf, zero
  );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor: d = a - b - bin, bout set when the bit
// position has to borrow from the next one.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor. Operands are captured in IDLE, then
// one bit per clock is pushed through a single full_sub cell, LSB first,
// with the borrow carried in a register. The result is presented in DONE
// until the consumer accepts it.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               br;
  logic               a_sign;
  logic               b_sign;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic               ovf_r;
  logic               zero_r;

  logic               d;
  logic               br_nxt;
  logic               last;
  logic [WIDTH-1:0]   diff_nxt;

  // The one shared subtractor cell, fed with the current LSBs each RUN cycle.
  full_sub u_full_sub (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d),
    .bout (br_nxt)
  );

  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign diff_nxt = {d, diff_r[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = ~rst;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result flag registration.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are cleared on reset so an aborted
    // operation leaves no stale result on the outputs.
    if (rst) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      br       <= 1'b0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            br     <= bus.bin;
            a_sign <= bus.a[WIDTH-1];
            b_sign <= bus.b[WIDTH-1];
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_nxt;
          diff_r <= diff_nxt;
          // The counter parks on its final value; only a capture rewinds it.
          if (last) begin
            borrow_r <= br_nxt;
            zero_r   <= (diff_nxt == '0);
            ovf_r    <= (a_sign != b_sign) && (d != a_sign);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_r;
  assign bus.ovf        = ovf_r;
  assign bus.zero       = zero_r;

endmodule
